// File: rtl/fir_pkg.sv
// Shared FIR constants and sample type used by the output buffer slice.
package fir_pkg;

    localparam int FIR_DATA_W     = 16;
    localparam int FIR_OBUF_DEPTH = 8;

    typedef logic [FIR_DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_out_buffer_if.sv
// Sample-in / FWFT-out bus of the FIR output buffer.
// Optional peak tracking ports exist only when FIR_OBUF_PEAK_EN is defined.
interface fir_out_buffer_if import fir_pkg::*; #(
    parameter int WIDTH = FIR_DATA_W,
    parameter int DEPTH = FIR_OBUF_DEPTH
);

    logic [WIDTH-1:0]         Yin;
    logic                     Yin_valid;
    logic [WIDTH-1:0]         Dout;
    logic                     Dout_valid;
    logic                     Dout_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
    logic                     overflow;
`ifdef FIR_OBUF_PEAK_EN
    logic                     peak_clr;
    logic [WIDTH-1:0]         peak;

    modport master (
        output Yin, Yin_valid, Dout_ready, peak_clr,
        input  Dout, Dout_valid, count, full, empty, overflow, peak
    );
    modport slave (
        input  Yin, Yin_valid, Dout_ready, peak_clr,
        output Dout, Dout_valid, count, full, empty, overflow, peak
    );
`else
    modport master (
        output Yin, Yin_valid, Dout_ready,
        input  Dout, Dout_valid, count, full, empty, overflow
    );
    modport slave (
        input  Yin, Yin_valid, Dout_ready,
        output Dout, Dout_valid, count, full, empty, overflow
    );
`endif

endinterface

// File: rtl/fir_obuf_mem.sv
// Sample storage: one synchronous write port, one asynchronous read port.
module fir_obuf_mem import fir_pkg::*; #(
    parameter int WIDTH = FIR_DATA_W,
    parameter int DEPTH = FIR_OBUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_out_buffer.sv
// First-word fall-through buffer for FIR output samples with sticky overflow.
// Define FIR_OBUF_PEAK_EN to add the registered unsigned peak tracker.
module fir_out_buffer import fir_pkg::*; #(
    parameter int WIDTH = FIR_DATA_W,
    parameter int DEPTH = FIR_OBUF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    fir_out_buffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, empty, push, pop;
    logic [WIDTH-1:0] rdata;

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        pop        = !empty && bus.Dout_ready;
        // A pop frees a slot in the same cycle, so a full buffer still accepts.
        push       = bus.Yin_valid && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (bus.Yin_valid & ~push);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    fir_obuf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.Yin),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Storage is not cleared by reset, so Dout is forced to 0 while empty.
    assign bus.Dout       = empty ? '0 : rdata;
    assign bus.Dout_valid = !empty;
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.overflow   = overflow_q;

`ifdef FIR_OBUF_PEAK_EN
    logic [WIDTH-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (bus.peak_clr) begin
            peak_d = push ? bus.Yin : '0;
        end else if (push && (bus.Yin > peak_q)) begin
            peak_d = bus.Yin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign bus.peak = peak_q;
`endif

endmodule
